// File: rtl/quad_esc_pkg.sv
// Shared types and helpers for the quad ESC PWM block.
// Contents:
//   state_e     - frame-level FSM states (ARM, RUN, FAILSAFE)
//   SPD_W/OFF_W - speed and offset word widths
//   calc_width  - saturating speed+offset, scaled, plus the zero-throttle pulse
package quad_esc_pkg;

    localparam int unsigned SPD_W = 11;
    localparam int unsigned OFF_W = 10;

    typedef enum logic [1:0] {
        ARM,
        RUN,
        FAILSAFE
    } state_e;

    // Pulse width in clocks for one channel.
    // The sum is one bit wider than a speed word so the carry flags saturation.
    function automatic int unsigned calc_width(
        input logic [SPD_W-1:0] spd,
        input logic [OFF_W-1:0] off,
        input int unsigned      min_pulse,
        input int unsigned      scale
    );
        logic [SPD_W:0]   sum;
        logic [SPD_W-1:0] sat;
        sum = {1'b0, spd} + {{(SPD_W + 1 - OFF_W){1'b0}}, off};
        sat = sum[SPD_W] ? {SPD_W{1'b1}} : sum[SPD_W-1:0];
        return min_pulse + ({{(32 - SPD_W){1'b0}}, sat} * scale);
    endfunction

endpackage

// File: rtl/esc_chnl.sv
// One ESC output channel: shadow speed, active pulse width and the pwm flop.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   cnt         - shared frame counter (current cycle)
//   cap         - capture spd into the shadow register
//   spd, off    - incoming speed word and quasi-static offset
//   load        - at this boundary, load a new active width
//   force_min   - at this boundary, force the active width to MIN_PULSE
//   bypass      - load source is spd directly instead of the shadow
//   pwm         - registered pulse output
module esc_chnl
    import quad_esc_pkg::*;
#(
    parameter int unsigned PERIOD_BITS = 20,
    parameter int unsigned MIN_PULSE   = 50000,
    parameter int unsigned SCALE       = 24
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PERIOD_BITS-1:0] cnt,
    input  logic                   cap,
    input  logic [SPD_W-1:0]       spd,
    input  logic [OFF_W-1:0]       off,
    input  logic                   load,
    input  logic                   force_min,
    input  logic                   bypass,
    output logic                   pwm
);

    localparam logic [PERIOD_BITS-1:0] MinW = PERIOD_BITS'(MIN_PULSE);

    logic [SPD_W-1:0]       shadow_q;
    logic [SPD_W-1:0]       src;
    logic [PERIOD_BITS-1:0] width_q;
    logic [PERIOD_BITS-1:0] width_d;
    logic [PERIOD_BITS-1:0] width_calc;
    logic [PERIOD_BITS-1:0] cnt_nxt;

    always_comb begin
        src        = bypass ? spd : shadow_q;
        width_calc = PERIOD_BITS'(calc_width(src, off, MIN_PULSE, SCALE));
        cnt_nxt    = cnt + PERIOD_BITS'(1);
        width_d    = width_q;
        if (force_min) begin
            width_d = MinW;
        end else if (load) begin
            width_d = width_calc;
        end
    end

    // pwm is registered against the counter value of the coming cycle, so the
    // width loaded at a boundary already governs the first cycle of the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            width_q  <= MinW;
            pwm      <= 1'b0;
        end else begin
            if (cap) begin
                shadow_q <= spd;
            end
            width_q <= width_d;
            pwm     <= (cnt_nxt < width_d);
        end
    end

endmodule

// File: rtl/quad_esc_pwm.sv
// Four-channel ESC servo-PWM generator fed by the flight controller.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   vld                  - one-cycle strobe, the four speed words are valid
//   *_spd (11b)          - motor speeds (front, back, left, right)
//   *_off (10b)          - per-motor offsets, quasi-static
//   *_pwm                - registered ESC pulse outputs
//   frm_strt             - high in the first cycle of every frame
//   armed                - high while in RUN
module quad_esc_pwm
    import quad_esc_pkg::*;
#(
    parameter int unsigned PERIOD_BITS = 20,
    parameter int unsigned MIN_PULSE   = 50000,
    parameter int unsigned SCALE       = 24,
    parameter int unsigned ARM_FRAMES  = 4,
    parameter int unsigned WDOG_FRAMES = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vld,
    input  logic [SPD_W-1:0] frnt_spd,
    input  logic [SPD_W-1:0] bck_spd,
    input  logic [SPD_W-1:0] lft_spd,
    input  logic [SPD_W-1:0] rght_spd,
    input  logic [OFF_W-1:0] frnt_off,
    input  logic [OFF_W-1:0] bck_off,
    input  logic [OFF_W-1:0] lft_off,
    input  logic [OFF_W-1:0] rght_off,
    output logic             frnt_pwm,
    output logic             bck_pwm,
    output logic             lft_pwm,
    output logic             rght_pwm,
    output logic             frm_strt,
    output logic             armed
);

    localparam int unsigned ArmW  = $clog2(ARM_FRAMES + 1);
    localparam int unsigned WdogW = $clog2(WDOG_FRAMES + 1);

    logic [PERIOD_BITS-1:0] cnt_q;
    state_e                 state_q, state_d;
    logic [ArmW-1:0]        arm_cnt_q, arm_cnt_d;
    logic [WdogW-1:0]       wdog_q, wdog_d;
    logic                   pending_q, pending_d;
    logic                   wrap, load, force_min, bypass, pend_eff;

    logic [SPD_W-1:0] spd_a [4];
    logic [OFF_W-1:0] off_a [4];
    logic [3:0]       pwm_a;

    assign spd_a[0] = frnt_spd;
    assign spd_a[1] = bck_spd;
    assign spd_a[2] = lft_spd;
    assign spd_a[3] = rght_spd;
    assign off_a[0] = frnt_off;
    assign off_a[1] = bck_off;
    assign off_a[2] = lft_off;
    assign off_a[3] = rght_off;

    assign frnt_pwm = pwm_a[0];
    assign bck_pwm  = pwm_a[1];
    assign lft_pwm  = pwm_a[2];
    assign rght_pwm = pwm_a[3];

    assign wrap     = &cnt_q;
    // A vld coinciding with the wrap counts as pending and is loaded directly.
    assign bypass   = wrap & vld;
    assign pend_eff = pending_q | vld;

    always_comb begin
        state_d   = state_q;
        arm_cnt_d = arm_cnt_q;
        wdog_d    = wdog_q;
        pending_d = pending_q | vld;
        load      = 1'b0;
        force_min = 1'b0;
        if (wrap) begin
            unique case (state_q)
                ARM: begin
                    // arm_cnt holds the index of the frame about to start.
                    if (arm_cnt_q == ArmW'(ARM_FRAMES)) begin
                        state_d   = RUN;
                        load      = 1'b1;
                        wdog_d    = '0;
                        pending_d = 1'b0;
                    end else begin
                        arm_cnt_d = arm_cnt_q + ArmW'(1);
                        force_min = 1'b1;
                    end
                end
                RUN: begin
                    if (pend_eff) begin
                        load      = 1'b1;
                        wdog_d    = '0;
                        pending_d = 1'b0;
                    end else if (wdog_q == WdogW'(WDOG_FRAMES - 1)) begin
                        state_d   = FAILSAFE;
                        force_min = 1'b1;
                        wdog_d    = '0;
                    end else begin
                        wdog_d = wdog_q + WdogW'(1);
                    end
                end
                FAILSAFE: begin
                    if (pend_eff) begin
                        state_d   = RUN;
                        load      = 1'b1;
                        wdog_d    = '0;
                        pending_d = 1'b0;
                    end else begin
                        force_min = 1'b1;
                    end
                end
                default: begin
                    state_d   = ARM;
                    force_min = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '1;
            state_q   <= ARM;
            arm_cnt_q <= '0;
            wdog_q    <= '0;
            pending_q <= 1'b0;
            frm_strt  <= 1'b0;
            armed     <= 1'b0;
        end else begin
            cnt_q     <= cnt_q + PERIOD_BITS'(1);
            state_q   <= state_d;
            arm_cnt_q <= arm_cnt_d;
            wdog_q    <= wdog_d;
            pending_q <= pending_d;
            frm_strt  <= wrap;
            armed     <= (state_d == RUN);
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_chnl
        esc_chnl #(
            .PERIOD_BITS(PERIOD_BITS),
            .MIN_PULSE  (MIN_PULSE),
            .SCALE      (SCALE)
        ) u_chnl (
            .clk      (clk),
            .rst_n    (rst_n),
            .cnt      (cnt_q),
            .cap      (vld),
            .spd      (spd_a[i]),
            .off      (off_a[i]),
            .load     (load),
            .force_min(force_min),
            .bypass   (bypass),
            .pwm      (pwm_a[i])
        );
    end

endmodule

// File: tb/tb_quad_esc_pwm.sv
// Self-checking bench for quad_esc_pwm. A monitor measures every frame's pulse
// widths per channel; each scenario task predicts those widths from the
// speed/offset arithmetic and the arming/watchdog rules, then compares.
module tb_quad_esc_pwm;

    localparam int PB    = 12;
    localparam int MINP  = 100;
    localparam int SC    = 1;
    localparam int ARMF  = 2;
    localparam int WDF   = 3;
    localparam int FRAME = 4096;
    localparam int NF    = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vld = 1'b0;
    logic [10:0] spd [4];
    logic [9:0]  off [4];
    logic        frnt_pwm, bck_pwm, lft_pwm, rght_pwm, frm_strt, armed;
    logic [3:0]  pwm_v;

    int total = 0;
    int bad   = 0;

    // Monitor state: current frame index since reset and cycle within frame.
    int cur_frame = -1;
    int pos = 0;
    int res_w   [NF][4];
    bit res_ok  [NF][4];
    bit res_arm [NF];
    bit res_val [NF];
    int exp_w   [NF][4];
    bit exp_arm [NF];

    assign pwm_v = {rght_pwm, lft_pwm, bck_pwm, frnt_pwm};

    quad_esc_pwm #(
        .PERIOD_BITS(PB),
        .MIN_PULSE  (MINP),
        .SCALE      (SC),
        .ARM_FRAMES (ARMF),
        .WDOG_FRAMES(WDF)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .vld     (vld),
        .frnt_spd(spd[0]),
        .bck_spd (spd[1]),
        .lft_spd (spd[2]),
        .rght_spd(spd[3]),
        .frnt_off(off[0]),
        .bck_off (off[1]),
        .lft_off (off[2]),
        .rght_off(off[3]),
        .frnt_pwm(frnt_pwm),
        .bck_pwm (bck_pwm),
        .lft_pwm (lft_pwm),
        .rght_pwm(rght_pwm),
        .frm_strt(frm_strt),
        .armed   (armed)
    );

    always #5 clk = ~clk;

    function automatic int exp_width(input int s, input int o);
        int t;
        t = s + o;
        if (t > 2047) t = 2047;
        return MINP + t * SC;
    endfunction

    // Per-frame measurement: high-cycle count and whether the high cycles form
    // one run starting at the frame's first cycle.
    initial begin : monitor
        int hi [4];
        int last [4];
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                cur_frame = -1;
                pos = 0;
                for (int f = 0; f < NF; f++) res_val[f] = 1'b0;
                for (int ch = 0; ch < 4; ch++) begin hi[ch] = 0; last[ch] = 0; end
            end else begin
                if (frm_strt === 1'b1) begin
                    if (cur_frame >= 0 && cur_frame < NF) begin
                        for (int ch = 0; ch < 4; ch++) begin
                            res_w[cur_frame][ch]  = hi[ch];
                            res_ok[cur_frame][ch] = (last[ch] == hi[ch]);
                        end
                        res_val[cur_frame] = 1'b1;
                    end
                    cur_frame++;
                    pos = 0;
                    for (int ch = 0; ch < 4; ch++) begin hi[ch] = 0; last[ch] = 0; end
                    if (cur_frame >= 0 && cur_frame < NF) res_arm[cur_frame] = armed;
                end else begin
                    pos++;
                end
                for (int ch = 0; ch < 4; ch++) begin
                    if (pwm_v[ch] === 1'b1) begin
                        hi[ch]++;
                        last[ch] = pos + 1;
                    end
                end
            end
        end
    end

    task automatic wait_frame(input int k);
        int n;
        int lim;
        n = 0;
        lim = (k - cur_frame + 2) * FRAME;
        while (cur_frame < k && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (cur_frame < k) begin
            total++;
            bad++;
            $display("FAIL wait_frame: frame=%0d required>=%0d", cur_frame, k);
        end
    endtask

    task automatic wait_pos(input int c);
        int n;
        n = 0;
        while (!(cur_frame >= 0 && pos == c) && n < 2 * FRAME + 16) begin
            @(negedge clk);
            n++;
        end
        if (!(cur_frame >= 0 && pos == c)) begin
            total++;
            bad++;
            $display("FAIL wait_pos: pos=%0d required=%0d", pos, c);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        vld = 1'b0;
        for (int ch = 0; ch < 4; ch++) begin
            spd[ch] = 11'($urandom_range(2047, 0));
            off[ch] = 10'($urandom_range(1023, 0));
        end
        repeat (4) @(negedge clk);
        total++;
        if (pwm_v !== 4'b0000) begin
            bad++; $display("FAIL reset_pwm: got=%b required=0000", pwm_v);
        end
        total++;
        if (frm_strt !== 1'b0) begin
            bad++; $display("FAIL reset_frm_strt: got=%b required=0", frm_strt);
        end
        total++;
        if (armed !== 1'b0) begin
            bad++; $display("FAIL reset_armed: got=%b required=0", armed);
        end
        // No vld seen: RUN starts from zero speeds, i.e. MIN_PULSE + offset.
        for (int f = 0; f < 3; f++) begin
            for (int ch = 0; ch < 4; ch++)
                exp_w[f][ch] = (f < ARMF) ? MINP : exp_width(0, int'(off[ch]));
            exp_arm[f] = (f == ARMF);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_arm;
        wait_frame(3);
        for (int f = 0; f < 3; f++) begin
            for (int ch = 0; ch < 4; ch++) begin
                total++;
                if (!res_val[f] || !res_ok[f][ch] || res_w[f][ch] != exp_w[f][ch]) begin
                    bad++;
                    $display("FAIL arm frame=%0d ch=%0d width=%0d contiguous=%0d valid=%0d required=%0d",
                             f, ch, res_w[f][ch], res_ok[f][ch], res_val[f], exp_w[f][ch]);
                end
            end
            total++;
            if (res_arm[f] !== exp_arm[f]) begin
                bad++; $display("FAIL arm_armed frame=%0d got=%0d required=%0d", f, res_arm[f], exp_arm[f]);
            end
        end
        for (int ch = 0; ch < 4; ch++) exp_w[3][ch] = exp_w[2][ch];
        exp_arm[3] = 1'b1;
    endtask

    task automatic test_update;
        int f;
        int f0;
        int c;
        f0 = cur_frame;
        f = f0;
        for (int i = 0; i < 4; i++) begin
            c = $urandom_range(4000, 1);
            wait_pos(c);
            f = cur_frame;
            for (int ch = 0; ch < 4; ch++) begin
                spd[ch] = 11'($urandom_range(2047, 0));
                off[ch] = 10'($urandom_range(1023, 0));
            end
            if (i == 0) begin spd[0] = 11'd500;  off[0] = 10'd20;   end
            if (i == 1) begin spd[0] = 11'd2047; off[0] = 10'd1023; end
            vld = 1'b1;
            @(negedge clk);
            vld = 1'b0;
            if (f + 1 >= 0 && f + 1 < NF) begin
                for (int ch = 0; ch < 4; ch++) exp_w[f + 1][ch] = exp_width(int'(spd[ch]), int'(off[ch]));
                exp_arm[f + 1] = 1'b1;
            end
            wait_frame(f + 1);
        end
        wait_frame(f + 2);
        for (int g = f0; g <= f + 1; g++) begin
            for (int ch = 0; ch < 4; ch++) begin
                total++;
                if (!res_val[g] || !res_ok[g][ch] || res_w[g][ch] != exp_w[g][ch]) begin
                    bad++;
                    $display("FAIL update frame=%0d ch=%0d width=%0d contiguous=%0d valid=%0d required=%0d",
                             g, ch, res_w[g][ch], res_ok[g][ch], res_val[g], exp_w[g][ch]);
                end
            end
            total++;
            if (res_arm[g] !== exp_arm[g]) begin
                bad++; $display("FAIL update_armed frame=%0d got=%0d required=%0d", g, res_arm[g], exp_arm[g]);
            end
        end
    endtask

    task automatic test_wrap_bypass;
        int f;
        f = cur_frame;
        for (int ch = 0; ch < 4; ch++) exp_w[f][ch] = exp_w[f - 1][ch];
        exp_arm[f] = 1'b1;
        // An earlier vld in the same frame must be overridden by the wrap-cycle one.
        wait_pos(1000);
        for (int ch = 0; ch < 4; ch++) spd[ch] = 11'($urandom_range(2047, 0));
        vld = 1'b1;
        @(negedge clk);
        vld = 1'b0;
        wait_pos(FRAME - 1);
        for (int ch = 0; ch < 4; ch++) spd[ch] = 11'($urandom_range(2047, 0));
        spd[2] = 11'd300;
        off[2] = 10'd0;
        vld = 1'b1;
        @(negedge clk);
        vld = 1'b0;
        for (int ch = 0; ch < 4; ch++) exp_w[f + 1][ch] = exp_width(int'(spd[ch]), int'(off[ch]));
        exp_arm[f + 1] = 1'b1;
        wait_frame(f + 2);
        for (int g = f; g <= f + 1; g++) begin
            for (int ch = 0; ch < 4; ch++) begin
                total++;
                if (!res_val[g] || !res_ok[g][ch] || res_w[g][ch] != exp_w[g][ch]) begin
                    bad++;
                    $display("FAIL bypass frame=%0d ch=%0d width=%0d contiguous=%0d valid=%0d required=%0d",
                             g, ch, res_w[g][ch], res_ok[g][ch], res_val[g], exp_w[g][ch]);
                end
            end
            total++;
            if (res_arm[g] !== exp_arm[g]) begin
                bad++; $display("FAIL bypass_armed frame=%0d got=%0d required=%0d", g, res_arm[g], exp_arm[g]);
            end
        end
    endtask

    task automatic test_watchdog;
        int f;
        int g0;
        f = cur_frame;
        // Last load was at the start of frame f-1; WDF silent boundaries later
        // the outputs drop to MIN_PULSE and stay there until a vld arrives.
        for (int k = 0; k < WDF + 1; k++) begin
            for (int ch = 0; ch < 4; ch++)
                exp_w[f + k][ch] = (k < WDF - 1) ? exp_w[f - 1][ch] : MINP;
            exp_arm[f + k] = (k < WDF - 1);
        end
        g0 = f + WDF;
        wait_frame(g0);
        for (int g = f; g < g0; g++) begin
            for (int ch = 0; ch < 4; ch++) begin
                total++;
                if (!res_val[g] || !res_ok[g][ch] || res_w[g][ch] != exp_w[g][ch]) begin
                    bad++;
                    $display("FAIL wdog frame=%0d ch=%0d width=%0d contiguous=%0d valid=%0d required=%0d",
                             g, ch, res_w[g][ch], res_ok[g][ch], res_val[g], exp_w[g][ch]);
                end
            end
            total++;
            if (res_arm[g] !== exp_arm[g]) begin
                bad++; $display("FAIL wdog_armed frame=%0d got=%0d required=%0d", g, res_arm[g], exp_arm[g]);
            end
        end
        wait_pos($urandom_range(4000, 1));
        for (int ch = 0; ch < 4; ch++) begin
            spd[ch] = 11'($urandom_range(2047, 0));
            off[ch] = 10'($urandom_range(1023, 0));
        end
        vld = 1'b1;
        @(negedge clk);
        vld = 1'b0;
        for (int ch = 0; ch < 4; ch++) exp_w[g0 + 1][ch] = exp_width(int'(spd[ch]), int'(off[ch]));
        exp_arm[g0 + 1] = 1'b1;
        wait_frame(g0 + 2);
        for (int g = g0; g <= g0 + 1; g++) begin
            for (int ch = 0; ch < 4; ch++) begin
                total++;
                if (!res_val[g] || !res_ok[g][ch] || res_w[g][ch] != exp_w[g][ch]) begin
                    bad++;
                    $display("FAIL recover frame=%0d ch=%0d width=%0d contiguous=%0d valid=%0d required=%0d",
                             g, ch, res_w[g][ch], res_ok[g][ch], res_val[g], exp_w[g][ch]);
                end
            end
            total++;
            if (res_arm[g] !== exp_arm[g]) begin
                bad++; $display("FAIL recover_armed frame=%0d got=%0d required=%0d", g, res_arm[g], exp_arm[g]);
            end
        end
    endtask

    task automatic test_reset_midframe;
        wait_pos(50);
        total++;
        if (pwm_v !== 4'b1111) begin
            bad++; $display("FAIL midframe_pwm_high: got=%b required=1111", pwm_v);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (pwm_v !== 4'b0000) begin
            bad++; $display("FAIL midframe_reset_pwm: got=%b required=0000", pwm_v);
        end
        total++;
        if (frm_strt !== 1'b0) begin
            bad++; $display("FAIL midframe_reset_frm_strt: got=%b required=0", frm_strt);
        end
        total++;
        if (armed !== 1'b0) begin
            bad++; $display("FAIL midframe_reset_armed: got=%b required=0", armed);
        end
        repeat (3) @(negedge clk);
        for (int ch = 0; ch < 4; ch++) off[ch] = 10'($urandom_range(1023, 0));
        // Shadow speeds are cleared by reset, so RUN again starts from offset only.
        for (int f = 0; f < 3; f++) begin
            for (int ch = 0; ch < 4; ch++)
                exp_w[f][ch] = (f < ARMF) ? MINP : exp_width(0, int'(off[ch]));
            exp_arm[f] = (f == ARMF);
        end
        rst_n = 1'b1;
        wait_frame(3);
        for (int f = 0; f < 3; f++) begin
            for (int ch = 0; ch < 4; ch++) begin
                total++;
                if (!res_val[f] || !res_ok[f][ch] || res_w[f][ch] != exp_w[f][ch]) begin
                    bad++;
                    $display("FAIL rearm frame=%0d ch=%0d width=%0d contiguous=%0d valid=%0d required=%0d",
                             f, ch, res_w[f][ch], res_ok[f][ch], res_val[f], exp_w[f][ch]);
                end
            end
            total++;
            if (res_arm[f] !== exp_arm[f]) begin
                bad++; $display("FAIL rearm_armed frame=%0d got=%0d required=%0d", f, res_arm[f], exp_arm[f]);
            end
        end
    endtask

    initial begin
        for (int ch = 0; ch < 4; ch++) begin
            spd[ch] = '0;
            off[ch] = '0;
        end
        test_reset();
        test_arm();
        test_update();
        test_wrap_bypass();
        test_watchdog();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/quad_esc_pwm.md
# quad_esc_pwm

Drives the four ESC servo-PWM lines from the motor-speed words that flght_cntrl produces on frnt_spd/bck_spd/lft_spd/rght_spd. It sits directly downstream of the flight controller: speeds are captured on a vld strobe, double-buffered and applied only at frame boundaries. Each channel's speed is offset-compensated, saturated and scaled into a pulse width on a shared frame counter. An arming sequence and a loss-of-update failsafe force minimum-throttle pulses when needed.

## Interface
- PERIOD_BITS, 20, frame counter width; frame = 2^PERIOD_BITS clocks
- MIN_PULSE, 50000, pulse width in clocks for zero throttle
- SCALE, 24, clocks per speed LSB
- ARM_FRAMES, 4, min-pulse frames after reset before RUN
- WDOG_FRAMES, 8, frames without vld (in RUN) before FAILSAFE
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- vld  in  1  one-cycle strobe: the four speed words are valid
- frnt_spd, bck_spd, lft_spd, rght_spd  in  11 each  unsigned motor speed
- frnt_off, bck_off, lft_off, rght_off  in  10 each  unsigned per-motor offset, quasi-static
- frnt_pwm, bck_pwm, lft_pwm, rght_pwm  out  1 each  ESC pulse outputs, registered
- frm_strt  out  1  high during the first cycle of every frame, registered
- armed  out  1  high while in RUN

## Operation
- Frame counter cnt (PERIOD_BITS) free-runs, wraps all-ones -> 0; wrap edge = frame boundary.
- Shadow regs: vld loads all four speeds into shadow and sets pending, in any state.
- Width per channel: sum = spd + off (12 b), saturate to 2047; width = MIN_PULSE + sum*SCALE. Widths are unsigned; the parameter set guarantees MIN_PULSE + 2047*SCALE < 2^PERIOD_BITS.
- Active widths update only at a frame boundary.
- FSM states: ARM, RUN, FAILSAFE (enum in package). All state changes happen only at frame boundaries.
- ARM: all channels output MIN_PULSE; count completed frames.
  - At the boundary ending frame ARM_FRAMES-1, go to RUN and load active widths from the shadow (zero speeds if no vld seen); clear pending.
- RUN: at each boundary, if pending, load active widths from the shadow and clear pending.
  - The watchdog counts boundaries since the last load; on reaching WDOG_FRAMES with no pending, go to FAILSAFE.
- FAILSAFE: all channels output MIN_PULSE.
  - At the first boundary with pending set, go to RUN and load the shadow; clear pending and the watchdog.
- vld in the same cycle as a wrap: the new speeds bypass the shadow and load straight into active (newest wins); pending ends cleared.
- armed = (state == RUN).

## Timing
- Reset values: cnt = all-ones, state = ARM, arm/watchdog counters 0, shadow 0, pending 0, active widths = MIN_PULSE, all pwm 0, frm_strt 0, armed 0.
- The first rising edge after rst_n deasserts is frame 0's boundary.
- Each pwm is high for exactly width cycles per frame: high in the cycles where cnt is in [0, width-1], low otherwise.
  - The rising edge coincides with the cnt -> 0 edge.
  - The width used is the one loaded at that same boundary; it is computed combinationally from the load source and registered together with pwm.
- frm_strt is high in the cycle cnt == 0; armed changes on the boundary edge.
- Latency: a vld at least 1 cycle before a wrap affects the very next frame. A vld in the wrap cycle also affects the next frame, via the bypass.
- Offset changes mid-frame take effect only at the next boundary load.
- rst_n asserted mid-frame: outputs go low immediately (asynchronously); no partial pulse is completed.

## Structure
- Package quad_esc_pkg holds: the state enum {ARM, RUN, FAILSAFE}, the SPD_W = 11 and OFF_W = 10 constants, and a width-calculation function (saturating add, scale, add MIN_PULSE).
- Sub-module esc_chnl, instantiated 4×: holds shadow speed, active width and pwm register. Inputs: cnt, load, force_min, bypass.
- The top level holds the counter, FSM, pending flag, watchdog and arm counter.

## Test plan
All scenarios use PERIOD_BITS = 12, MIN_PULSE = 100, SCALE = 1, ARM_FRAMES = 2, WDOG_FRAMES = 3.
- Reset release with vld held 0 -> frames 0-1: all pwm high for 100 cycles per 4096-cycle frame, armed = 0. Frame 2: armed = 1, widths = 100 + off.
- In RUN, vld with frnt = 500, off = 20 at cnt = 2000 -> next frame frnt_pwm high for 620 cycles; the current frame is unchanged.
- frnt_spd = 2047, frnt_off = 1023 -> saturation: width = 2147 cycles.
- vld in the cycle cnt = 4095 with lft = 300, off = 0 -> lft_pwm high for 400 cycles in the frame that starts on the next edge.
- In RUN, no vld for 3 boundaries -> FAILSAFE: armed = 0, all pwm width 100. One vld -> RUN at the next boundary with the new widths.
- rst_n pulsed low at cnt = 50 while pwm is high -> all pwm 0 and frm_strt 0 immediately; after release, ARM restarts from frame 0.
